// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch response path.
//   NOP_INSTR     : instruction substituted into entries whose PC is misaligned
//   fetch_entry_t : one queued fetch result {pc, instr, fault}
//   pc_misaligned : true when a PC is not on a 4-byte boundary
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk, rst   : clock, asynchronous active-high reset (pointers/count only)
//   clear      : synchronous discard of all entries, wins over push/pop
//   push, push_data : write one entry at the tail
//   pop        : retire the head entry
//   head       : entry at the read pointer (meaningful when count != 0)
//   count      : number of valid entries, 0..DEPTH
// The owner guarantees no push when full and no pop when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else if (clear) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care after reset or clear.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_r[wr_ptr_r] <= push_data;
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/fetch_resp_queue_chk.sv
// Checker for fetch_resp_queue occupancy.
//   clk, rst  : clock and asynchronous active-high reset
//   count     : entries currently held in the queue
//   inflight  : one memory read outstanding
// Accepted-but-unretired work (queued plus in flight) must never exceed DEPTH.
module fetch_resp_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          rst,
  input logic [CW-1:0] count,
  input logic          inflight
);

  logic [CW:0] occ_s;

  assign occ_s = {1'b0, count} + {{CW{1'b0}}, inflight};

  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
    occ_s <= (CW+1)'(DEPTH));

endmodule

// File: rtl/fetch_resp_queue.sv
// Fetch response queue: accepts PCs from the fetch stage, issues one
// synchronous instruction-memory read per accepted PC, and queues
// {pc, instr, fault} for decode.
//   clk, rst      : clock, asynchronous active-high reset
//   s_valid_i/s_ready_o/s_pc_i : PC stream from the PC generator
//   imem_req_o/imem_addr_o     : read strobe and byte address
//   imem_rdata_i  : read data, valid one cycle after imem_req_o
//   m_valid_o/m_ready_i        : queue head handshake to decode
//   m_pc_o/m_instr_o/m_fault_o : queue head contents
//   flush_i       : branch redirect, discards queued and in-flight work
module fetch_resp_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [31:0] m_pc_o,
  output logic [31:0] m_instr_o,
  output logic        m_fault_o,
  input  logic        flush_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          inflight_r;
  logic [31:0]   pc_r;
  logic          fault_r;
  logic [CW-1:0] count_s;
  logic [CW:0]   occ_s;
  logic          acc_s;
  logic          push_s;
  logic          pop_s;
  fetch_entry_t  wr_entry_s;
  fetch_entry_t  head_s;

  // The in-flight read reserves a slot, so ready looks at queued plus
  // outstanding work; a pop this cycle deliberately does not free a slot.
  assign occ_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};

  // Upstream handshake and memory request generation.
  always_comb begin
    s_ready_o  = 1'b0;
    imem_req_o = 1'b0;
    if (!rst && !flush_i && (occ_s < (CW+1)'(DEPTH))) begin
      s_ready_o = 1'b1;
    end else begin
      s_ready_o = 1'b0;
    end
    acc_s = s_valid_i & s_ready_o;
    if (acc_s && !pc_misaligned(s_pc_i)) begin
      imem_req_o = 1'b1;
    end else begin
      imem_req_o = 1'b0;
    end
  end

  assign imem_addr_o = s_pc_i;

  // Remembers the accepted PC until its read data returns next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r <= 1'b0;
      pc_r       <= 32'h0000_0000;
      fault_r    <= 1'b0;
    end else if (flush_i) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= acc_s;
      if (acc_s) begin
        pc_r    <= s_pc_i;
        fault_r <= pc_misaligned(s_pc_i);
      end
    end
  end

  // Faulting entries never issued a read, so the bus data is replaced.
  always_comb begin
    wr_entry_s.pc    = pc_r;
    wr_entry_s.fault = fault_r;
    if (fault_r) begin
      wr_entry_s.instr = NOP;
    end else begin
      wr_entry_s.instr = imem_rdata_i;
    end
  end

  // A flush drops the response arriving this cycle and blocks any pop.
  assign push_s    = inflight_r & ~flush_i;
  assign m_valid_o = (count_s != CW'(0)) & ~flush_i;
  assign pop_s     = m_valid_o & m_ready_i;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_i),
    .push      (push_s),
    .push_data (wr_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s)
  );

  assign m_pc_o    = head_s.pc;
  assign m_instr_o = head_s.instr;
  assign m_fault_o = head_s.fault;

  fetch_resp_queue_chk #(.DEPTH(DEPTH)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .count    (count_s),
    .inflight (inflight_r)
  );

endmodule

// File: tb/tb_fetch_resp_queue.sv
// Self-checking bench for fetch_resp_queue. A transaction-level model
// (a queue of accepted entries, each visible two cycles after acceptance)
// predicts every handshake and head value; scenario tasks add their own checks.
module tb_fetch_resp_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] s_pc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic [31:0] m_pc_o;
  logic [31:0] m_instr_o;
  logic        m_fault_o;
  logic        flush_i = 1'b0;

  fetch_resp_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .s_pc_i       (s_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_pc_o       (m_pc_o),
    .m_instr_o    (m_instr_o),
    .m_fault_o    (m_fault_o),
    .flush_i      (flush_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    int          avail;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          req_cnt = 0;
  int          dut_pops = 0;
  int          acc_cyc[$];
  logic [31:0] acc_pc[$];
  int          pop_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  logic        pop_fault[$];
  logic        req_q = 1'b0;
  logic [31:0] addr_q = 32'h0;
  logic        er, emv, ereq;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Memory model: answers a request one cycle later.
  always @(posedge clk) imem_rdata_i <= req_q ? mem_fn(addr_q) : 32'hBAD0_BAD0;

  // Scoreboard: compare every cycle mid-period, then advance the model.
  always @(negedge clk) begin
    req_q  = imem_req_o;
    addr_q = imem_addr_o;
    er   = !rst && !flush_i && (q.size() < DEPTH);
    emv  = !rst && !flush_i && (q.size() > 0) && (q[0].avail <= cyc);
    ereq = er && s_valid_i && (s_pc_i[1:0] == 2'b00);
    checks++;
    if (s_ready_o !== er) begin
      failures++;
      $display("FAIL s_ready cyc=%0d got=%b exp=%b", cyc, s_ready_o, er);
    end
    checks++;
    if (m_valid_o !== emv) begin
      failures++;
      $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, m_valid_o, emv);
    end
    checks++;
    if (imem_req_o !== ereq) begin
      failures++;
      $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req_o, ereq);
    end
    if (ereq) begin
      checks++;
      if (imem_addr_o !== s_pc_i) begin
        failures++;
        $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr_o, s_pc_i);
      end
    end
    if (emv) begin
      checks++;
      if (m_pc_o !== q[0].pc || m_instr_o !== q[0].instr || m_fault_o !== q[0].fault) begin
        failures++;
        $display("FAIL head cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, m_pc_o, m_instr_o,
                 m_fault_o, q[0].pc, q[0].instr, q[0].fault);
      end
    end
    if (imem_req_o === 1'b1) req_cnt++;
    if (m_valid_o === 1'b1 && m_ready_i === 1'b1) dut_pops++;
    if (rst || flush_i) begin
      q.delete();
    end else begin
      if (emv && m_ready_i) begin
        pop_cyc.push_back(cyc);
        pop_pc.push_back(q[0].pc);
        pop_instr.push_back(m_instr_o);
        pop_fault.push_back(m_fault_o);
        void'(q.pop_front());
      end
      if (s_valid_i && er) begin
        e.pc    = s_pc_i;
        e.fault = |s_pc_i[1:0];
        e.instr = e.fault ? NOP : mem_fn(s_pc_i);
        e.avail = cyc + 2;
        q.push_back(e);
        acc_cyc.push_back(cyc);
        acc_pc.push_back(s_pc_i);
      end
    end
    cyc++;
  end

  task automatic clear_logs();
    acc_cyc.delete(); acc_pc.delete(); pop_cyc.delete();
    pop_pc.delete(); pop_instr.delete(); pop_fault.delete();
    req_cnt = 0;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic mr, input logic fl);
    s_valid_i = v; s_pc_i = pc; m_ready_i = mr; flush_i = fl;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready_o !== 1'b0 || m_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b mv=%b req=%b exp 0/0/0", s_ready_o, m_valid_o, imem_req_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready_o !== 1'b1 || m_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got rdy=%b mv=%b exp 1/0", s_ready_o, m_valid_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    clear_logs();
    drive(1'b1, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h4, 1'b1, 1'b0);
    drive(1'b1, 32'h8, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (req_cnt != 3 || acc_cyc.size() != 3) begin
      failures++;
      $display("FAIL b2b_accepts got req=%0d acc=%0d exp 3/3", req_cnt, acc_cyc.size());
    end
    checks++;
    if (pop_pc.size() != 3) begin
      failures++;
      $display("FAIL b2b_pops got=%0d exp=3", pop_pc.size());
    end else if (pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4 || pop_pc[2] !== 32'h8 ||
                 pop_cyc[1] != pop_cyc[0] + 1 || pop_cyc[2] != pop_cyc[0] + 2 ||
                 pop_cyc[0] != acc_cyc[0] + 2) begin
      failures++;
      $display("FAIL b2b_order got pcs=%h,%h,%h first_pop_delay=%0d exp 0,4,8 delay 2",
               pop_pc[0], pop_pc[1], pop_pc[2], pop_cyc[0] - acc_cyc[0]);
    end
  endtask

  task automatic test_fill_drain();
    clear_logs();
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h100 + 32'(4 * acc_pc.size()), 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (acc_pc.size() != 4 || s_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL fill got acc=%0d rdy=%b exp 4/0", acc_pc.size(), s_ready_o);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (pop_pc.size() != 4) begin
      failures++;
      $display("FAIL drain_count got=%0d exp=4", pop_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pop_pc[i] !== 32'h100 + 32'(4 * i) || pop_instr[i] !== mem_fn(32'h100 + 32'(4 * i))) begin
          failures++;
          $display("FAIL drain_entry%0d got=%h/%h exp=%h/%h", i, pop_pc[i], pop_instr[i],
                   32'h100 + 32'(4 * i), mem_fn(32'h100 + 32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_misaligned();
    clear_logs();
    drive(1'b1, 32'h102, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (req_cnt != 0 || pop_pc.size() != 1) begin
      failures++;
      $display("FAIL misaligned_flow got req=%0d pops=%0d exp 0/1", req_cnt, pop_pc.size());
    end else if (pop_pc[0] !== 32'h102 || pop_instr[0] !== NOP || pop_fault[0] !== 1'b1) begin
      failures++;
      $display("FAIL misaligned_entry got=%h/%h/%b exp=00000102/00000013/1",
               pop_pc[0], pop_instr[0], pop_fault[0]);
    end
  endtask

  task automatic test_flush();
    clear_logs();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
    s_valid_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid_o !== 1'b0 || s_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle got mv=%b rdy=%b exp 0/0", m_valid_o, s_ready_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_next got mv=%b exp 0", m_valid_o);
    end
    @(posedge clk); #1;
    clear_logs();
    drive(1'b1, 32'h200, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (pop_pc.size() != 1 || pop_pc[0] !== 32'h200) begin
      failures++;
      $display("FAIL flush_after got pops=%0d first=%h exp 1/00000200", pop_pc.size(),
               (pop_pc.size() > 0) ? pop_pc[0] : 32'h0);
    end
  endtask

  task automatic test_full_pop();
    clear_logs();
    for (int i = 0; i < 6; i++) drive(1'b1, 32'h500 + 32'(4 * acc_pc.size()), 1'b0, 1'b0);
    s_valid_i = 1'b1; s_pc_i = 32'h510; m_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready_o !== 1'b0 || m_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_cycle got rdy=%b mv=%b exp 0/1", s_ready_o, m_valid_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (s_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_next got rdy=%b exp 1", s_ready_o);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (acc_pc.size() != 5 || pop_pc.size() != 5 || pop_pc[pop_pc.size() - 1] !== 32'h510) begin
      failures++;
      $display("FAIL full_pop_drain got acc=%0d pops=%0d exp 5/5 last 00000510",
               acc_pc.size(), pop_pc.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    drive(1'b1, 32'h600, 1'b0, 1'b0);
    drive(1'b1, 32'h604, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid_o !== 1'b0 || s_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got mv=%b rdy=%b exp 0/0", m_valid_o, s_ready_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got rdy=%b exp 1", s_ready_o);
    end
    @(posedge clk); #1;
    drive(1'b1, 32'h700, 1'b1, 1'b0);
    drive(1'b1, 32'h704, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (pop_pc.size() != 2 || pop_pc[0] !== 32'h700 || pop_pc[1] !== 32'h704) begin
      failures++;
      $display("FAIL reset_fresh got pops=%0d exp 2 (00000700,00000704)", pop_pc.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    int          model_pops;
    clear_logs();
    dut_pops = 0;
    for (int i = 0; i < 400; i++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      drive(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0));
    end
    for (int i = 0; i < 10; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    model_pops = pop_pc.size();
    checks++;
    if (m_valid_o !== 1'b0 || dut_pops != model_pops) begin
      failures++;
      $display("FAIL random_end got mv=%b pops=%0d exp mv=0 pops=%0d", m_valid_o, dut_pops, model_pops);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    test_reset();
    test_back_to_back();
    test_fill_drain();
    test_misaligned();
    test_flush();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
